// File: rtl/operand_store_if.sv
// Request/response bundle between the operand-entry controller and operand_store.
// The master drives requests; the store (slave) returns data and stack status.
interface operand_store_if #(
   parameter int n = 17,
   parameter int m = 3
);
   logic         enable;
   logic         mode;
   logic         ReadWrite;
   logic [m-1:0] Address;
   logic [n-1:0] DataIn;
   logic         push;
   logic         pop;
   logic [n-1:0] DataOut;
   logic         valid;
   logic [m:0]   count;
   logic         full;
   logic         empty;
   logic         error;

   modport master (
      output enable, mode, ReadWrite, Address, DataIn, push, pop,
      input  DataOut, valid, count, full, empty, error
   );

   modport slave (
      input  enable, mode, ReadWrite, Address, DataIn, push, pop,
      output DataOut, valid, count, full, empty, error
   );
endinterface

// File: rtl/operand_store.sv
// Shared operand array usable as addressed RAM or as a LIFO stack (Mem[0..count-1]).
// One registered read port feeds DataOut/valid; one write port serves RAM writes and pushes.
module operand_store #(
   parameter int n     = 17,
   parameter int m     = 3,
   parameter int pow2m = 8
) (
   input  logic             clock,
   input  logic             reset,
   operand_store_if.slave   bus
);
   logic [n-1:0] mem [pow2m];
   logic [n-1:0] dout_q;
   logic         valid_q;
   logic [m:0]   count_q;
   logic         error_q;

   logic         full_w, empty_w;
   logic         wr_en, rd_en, err_set;
   logic [m-1:0] wr_addr, rd_addr, top;
   logic [m:0]   cnt_nxt;

   assign full_w  = (count_q == (m+1)'(pow2m));
   assign empty_w = (count_q == '0);
   assign top     = count_q[m-1:0] - 1'b1;

   // Decode one operation per cycle into at most one read and one write of the array.
   always_comb begin
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_set = 1'b0;
      wr_addr = bus.Address;
      rd_addr = bus.Address;
      cnt_nxt = count_q;
      if (bus.enable) begin
         if (!bus.mode) begin
            rd_en = bus.ReadWrite;
            wr_en = !bus.ReadWrite;
         end else begin
            case ({bus.push, bus.pop})
               2'b10: begin
                  if (full_w) err_set = 1'b1;
                  else begin
                     wr_en   = 1'b1;
                     wr_addr = count_q[m-1:0];
                     cnt_nxt = count_q + 1'b1;
                  end
               end
               2'b01: begin
                  if (empty_w) err_set = 1'b1;
                  else begin
                     rd_en   = 1'b1;
                     rd_addr = top;
                     cnt_nxt = count_q - 1'b1;
                  end
               end
               2'b11: begin
                  // Replace top: read returns the pre-edge value of the same entry.
                  if (empty_w) err_set = 1'b1;
                  else begin
                     rd_en   = 1'b1;
                     wr_en   = 1'b1;
                     rd_addr = top;
                     wr_addr = top;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < pow2m; j++) mem[j] <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         if (wr_en) mem[wr_addr] <= bus.DataIn;
         if (rd_en) dout_q <= mem[rd_addr];
         valid_q <= rd_en;
         count_q <= cnt_nxt;
         if (err_set) error_q <= 1'b1;
      end
   end

   assign bus.DataOut = dout_q;
   assign bus.valid   = valid_q;
   assign bus.count   = count_q;
   assign bus.full    = full_w;
   assign bus.empty   = empty_w;
   assign bus.error   = error_q;
endmodule

// File: tb/tb_operand_store.sv
// Scoreboarded random/directed bench for operand_store against a plain array+stack-pointer model.
module tb_operand_store;
   localparam int N = 17;
   localparam int M = 3;
   localparam int D = 8;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   operand_store_if #(.n(N), .m(M)) bus ();
   operand_store #(.n(N), .m(M), .pow2m(D)) dut (.clock(clock), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   logic [N-1:0] mdl [D];
   int           sp;
   logic         merr;
   logic [N-1:0] mdout;
   logic [N-1:0] exp_q [$];
   bit           checking = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: any valid strobe must match the oldest expected read; DataOut must always match.
   always @(negedge clock) begin
      if (checking) begin
         if (bus.valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("read_data", bus.DataOut, exp_q.pop_front());
         end else if (exp_q.size() != 0) begin
            chk("missing_valid", bus.valid, 1);
            void'(exp_q.pop_front());
         end else begin
            chk("valid_low", bus.valid, 0);
         end
         chk("dataout_hold", bus.DataOut, mdout);
      end
   end

   task automatic check_status();
      chk("count", bus.count, sp);
      chk("full", bus.full, sp == D);
      chk("empty", bus.empty, sp == 0);
      chk("error", bus.error, merr);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int j = 0; j < D; j++) mdl[j] = '0;
      sp = 0; merr = 0; mdout = '0;
      check_status();
   endtask

   task automatic op(input bit en, input bit md, input bit rw, input logic [M-1:0] a,
                     input logic [N-1:0] din, input bit ps, input bit pp);
      bit v = 0;
      logic [N-1:0] rd = '0;
      if (en) begin
         if (!md) begin
            if (rw) begin rd = mdl[a]; v = 1; end
            else mdl[a] = din;
         end else if (ps && !pp) begin
            if (sp == D) merr = 1;
            else begin mdl[sp] = din; sp++; end
         end else if (pp && !ps) begin
            if (sp == 0) merr = 1;
            else begin sp--; rd = mdl[sp]; v = 1; end
         end else if (ps && pp) begin
            if (sp == 0) merr = 1;
            else begin rd = mdl[sp-1]; mdl[sp-1] = din; v = 1; end
         end
      end
      bus.enable = en; bus.mode = md; bus.ReadWrite = rw; bus.Address = a;
      bus.DataIn = din; bus.push = ps; bus.pop = pp;
      @(posedge clock); #1;
      if (v) begin exp_q.push_back(rd); mdout = rd; end
      check_status();
   endtask

   task automatic ram_wr(input logic [M-1:0] a, input logic [N-1:0] d); op(1, 0, 0, a, d, 0, 0); endtask
   task automatic ram_rd(input logic [M-1:0] a); op(1, 0, 1, a, '0, 0, 0); endtask
   task automatic spush(input logic [N-1:0] d); op(1, 1, 0, '0, d, 1, 0); endtask
   task automatic spop(); op(1, 1, 0, '0, '0, 0, 1); endtask
   task automatic srep(input logic [N-1:0] d); op(1, 1, 0, '0, d, 1, 1); endtask
   task automatic idle(); op(0, 0, 0, '0, '0, 0, 0); endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus.enable = 0; bus.mode = 0; bus.ReadWrite = 0; bus.Address = '0;
      bus.DataIn = '0; bus.push = 0; bus.pop = 0;
      do_reset();
      checking = 1;

      // RAM write then read back
      ram_wr(3'd5, 17'h1ABCD);
      ram_rd(3'd5);
      idle();

      // basic LIFO
      spush(1); spush(2); spush(3);
      spop(); spop(); spop();

      // overflow with full stack, then drain
      for (int i = 1; i <= 8; i++) spush(17'(i));
      spush(17'h1FFFF);
      for (int i = 0; i < 8; i++) spop();

      // underflow on empty
      do_reset();
      spop();
      srep(17'h55);

      // replace top
      do_reset();
      spush(7); srep(9); spop();

      // enable low holds state, then reset mid-sequence
      do_reset();
      for (int i = 0; i < 4; i++) spush(17'(10 + i));
      for (int i = 0; i < 3; i++) op(0, 1, 0, '0, 17'h77, 1, 0);
      do_reset();
      ram_rd(3'd0);

      // random mix, biased toward enabled stack traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else op($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
                 3'($urandom), 17'($urandom), 1'($urandom), 1'($urandom));
      end

      @(negedge clock);
      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/operand_store.md
# operand_store

Parametrised synchronous storage block for the calculator datapath, the successor to the original single-mode memory. It keeps the addressed read/write mode and adds a LIFO stack mode, so operands can be pushed and popped during expression evaluation without the control FSM tracking addresses. Both modes share one array, with a registered data output and valid strobe, full/empty status and a sticky error flag. It sits between the keypad/operand-entry logic and the ALU.

## Interface
- n, 17, data word width (DataIn, DataOut, array entry)
- m, 3, address width
- pow2m, 8, array depth; must equal 2**m

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  operation qualifier; 0 = no array/pointer change
- mode  in  1  0 = RAM mode, 1 = stack mode
- ReadWrite  in  1  RAM mode only: 1 = read, 0 = write
- Address  in  m  RAM mode word address
- DataIn  in  n  write / push data
- push  in  1  stack mode push request
- pop  in  1  stack mode pop request
- DataOut  out  n  registered read/pop data
- valid  out  1  DataOut updated this cycle (1-cycle pulse)
- count  out  m+1  stack occupancy, 0..pow2m
- full  out  1  count == pow2m (combinational from count register)
- empty  out  1  count == 0 (combinational from count register)
- error  out  1  sticky overflow/underflow flag

## Operation
- Reset: Mem[j] <= 0 for all j; DataOut <= 0; valid <= 0; count <= 0; error <= 0. Reset takes priority over all inputs and aborts any in-progress operation.
- enable=0: array, count, DataOut unchanged; valid <= 0. No tristate output; DataOut holds its last value.
- RAM mode (mode=0, enable=1); push/pop ignored; count unchanged:
  - ReadWrite=1: DataOut <= Mem[Address]; valid <= 1.
  - ReadWrite=0: Mem[Address] <= DataIn; valid <= 0.
- Stack mode (mode=1, enable=1); Address/ReadWrite ignored; stack occupies Mem[0..count-1], top = Mem[count-1]:
  - push only: if !full, Mem[count] <= DataIn and count+1; else error <= 1, no change. valid <= 0.
  - pop only: if !empty, DataOut <= Mem[count-1], count-1, valid <= 1; else error <= 1, valid <= 0, DataOut unchanged.
  - push and pop (replace top): if !empty, DataOut <= old Mem[count-1], Mem[count-1] <= DataIn, count unchanged, valid <= 1; if empty, error <= 1, no change.
  - neither: idle, valid <= 0.
- The array is shared. RAM writes may modify stack contents, and count does not change in RAM mode.
- error is set only by an overflow/underflow and cleared only by reset.
- Address arithmetic wraps modulo pow2m by width. count is m+1 bits, so pow2m is representable.

## Timing
- Read latency 1: a request at edge k gives DataOut/valid at edge k; visible after k, for exactly one cycle for valid.
- A write/push at edge k is readable by a request at edge k+1 (no bypass needed within a cycle; replace-top returns the old value).
- full/empty/count reflect the state after the last edge; error rises on the edge of the offending request.
- mode may change every cycle; each cycle is decoded independently.

## Test plan
- Reset, then RAM write 0x1ABCD to addr 5, read addr 5 next cycle -> DataOut=0x1ABCD, valid=1 for one cycle; count=0.
- Stack: push 1,2,3 -> count=3; pop -> DataOut=3, valid=1, count=2; pop, pop -> 2, 1; empty=1.
- Push 8 values -> full=1; 9th push -> error=1, count=8, Mem unchanged; subsequent pops return values 8..1 in LIFO order, error stays 1.
- Reset, pop on empty -> error=1, valid=0, DataOut=0; push+pop on empty -> error=1, count=0.
- Push 7, then push+pop with DataIn=9 -> DataOut=7, valid=1, count=1; pop -> 9.
- Push 4 values, enable=0 with push=1 for 3 cycles -> no change, valid=0; assert reset mid-sequence -> count=0, error=0, DataOut=0, RAM read of addr 0 returns 0.
